// File: rtl/spell_pkg.sv
// Shared SPELL constants: shared-RAM bus widths and
// the state codes of the shared-RAM responder FSM.
package spell_pkg;

   localparam int RAMBUS_ADDR_W = 10;
   localparam int RAMBUS_DATA_W = 32;

   typedef logic [2:0] resp_state_t;

   localparam resp_state_t RespClear = 3'd0;
   localparam resp_state_t RespIdle  = 3'd1;
   localparam resp_state_t RespWait  = 3'd2;
   localparam resp_state_t RespAck   = 3'd3;
   localparam resp_state_t RespGap   = 3'd4;

endpackage

// File: rtl/spell_rambus_mem.sv
// Word storage behind the shared-RAM responder: byte-write
// port plus combinational read, swappable for a RAM macro.
module spell_rambus_mem
   import spell_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic                     clock,
   input  logic [3:0]               i_be,
   input  logic [AW-1:0]            i_waddr,
   input  logic [RAMBUS_DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]            i_raddr,
   output logic [RAMBUS_DATA_W-1:0] o_rdata
);

   logic [RAMBUS_DATA_W-1:0] mem_q [DEPTH];

   // Commit only the enabled byte lanes of the addressed word
   always_ff @(posedge clock) begin
      for (int b = 0; b < 4; b++) begin
         if (i_be[b]) begin
            mem_q[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/spell_rambus_responder.sv
// Wishbone classic responder terminating the SPELL shared-RAM
// port: optional clear after reset, wait states, one-cycle ack.
module spell_rambus_responder
   import spell_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1,
   parameter bit INIT_ZERO   = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_wb_cyc,
   input  logic                     i_wb_stb,
   input  logic                     i_wb_we,
   input  logic [3:0]               i_wb_sel,
   input  logic [RAMBUS_ADDR_W-1:0] i_wb_addr,
   input  logic [RAMBUS_DATA_W-1:0] i_wb_data,
   output logic                     o_wb_ack,
   output logic [RAMBUS_DATA_W-1:0] o_wb_data,
   output logic                     o_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LG = $clog2(DEPTH);
   localparam logic [3:0] WS_LOAD =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam resp_state_t RST_STATE =
      INIT_ZERO ? RespClear : RespIdle;
   localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

   resp_state_t state_q, state_d;
   logic [3:0]               wait_q, wait_d;
   logic [AW-1:0]            clr_q, clr_d;
   logic                     we_q, we_d;
   logic [3:0]               sel_q, sel_d;
   logic [7:0]               idx_q, idx_d;
   logic [RAMBUS_DATA_W-1:0] data_q, data_d;

   logic [3:0]               mem_be;
   logic [AW-1:0]            mem_waddr;
   logic [RAMBUS_DATA_W-1:0] mem_wdata;
   logic [RAMBUS_DATA_W-1:0] mem_rdata;
   logic                     in_range;
   logic                     unused_addr_lsb;

   // Byte offset bits carry no meaning on a word-wide bus
   assign unused_addr_lsb = ^i_wb_addr[1:0];

   // Word indices past DEPTH alias nothing: reads give 0, writes drop
   assign in_range = (({1'b0, idx_q} >> LG) == 9'd0);

   // State, counters and latched request fields
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RST_STATE;
         wait_q  <= 4'd0;
         clr_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         idx_q   <= 8'd0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         clr_q   <= clr_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   // Next state: request capture in IDLE, wait countdown with abort
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      clr_d   = clr_q;
      we_d    = we_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      data_d  = data_q;
      case (state_q)
         RespClear: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == CLR_LAST) state_d = RespIdle;
         end
         RespIdle: begin
            if (i_wb_cyc && i_wb_stb) begin
               we_d    = i_wb_we;
               sel_d   = i_wb_sel;
               idx_d   = i_wb_addr[9:2];
               data_d  = i_wb_data;
               wait_d  = WS_LOAD;
               state_d = (WAIT_STATES > 0) ? RespWait : RespAck;
            end
         end
         RespWait: begin
            if (!i_wb_cyc)          state_d = RespIdle;
            else if (wait_q == 4'd0) state_d = RespAck;
            else                    wait_d  = wait_q - 4'd1;
         end
         RespAck: state_d = RespGap;
         RespGap: state_d = RespIdle;
         default: state_d = RespIdle;
      endcase
   end

   // Outputs and memory port; writes are suppressed while in reset
   always_comb begin
      mem_be    = 4'd0;
      mem_waddr = idx_q[AW-1:0];
      mem_wdata = data_q;
      o_wb_ack  = 1'b0;
      o_wb_data = '0;
      o_ready   = (state_q != RespClear);
      case (state_q)
         RespClear: begin
            mem_waddr = clr_q;
            mem_wdata = '0;
            if (!reset) mem_be = 4'hF;
         end
         RespAck: begin
            o_wb_ack = 1'b1;
            if (we_q) begin
               if (in_range && !reset) mem_be = sel_q;
            end else if (in_range) begin
               o_wb_data = mem_rdata;
            end
         end
         default: ;
      endcase
   end

   spell_rambus_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock   (clock),
      .i_be    (mem_be),
      .i_waddr (mem_waddr),
      .i_wdata (mem_wdata),
      .i_raddr (idx_q[AW-1:0]),
      .o_rdata (mem_rdata)
   );

endmodule

// File: tb/tb_spell_rambus_responder.sv
// Bench for spell_rambus_responder: three configurations driven
// by per-scenario tasks against a word-array reference model.
module tb_spell_rambus_responder;

   logic        clk = 1'b0;
   logic        rst  [3];
   logic        cyc  [3];
   logic        stb  [3];
   logic        we   [3];
   logic [3:0]  sel  [3];
   logic [9:0]  addr [3];
   logic [31:0] wdat [3];
   logic        ack  [3];
   logic [31:0] rdat [3];
   logic        rdy  [3];

   int dep [3] = '{256, 64, 16};
   int ws  [3] = '{1, 3, 2};

   logic [31:0] mdl [3][256];

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spell_rambus_responder #(
      .DEPTH(256), .WAIT_STATES(1), .INIT_ZERO(1'b1)
   ) u_d0 (
      .clock(clk), .reset(rst[0]), .i_wb_cyc(cyc[0]),
      .i_wb_stb(stb[0]), .i_wb_we(we[0]), .i_wb_sel(sel[0]),
      .i_wb_addr(addr[0]), .i_wb_data(wdat[0]),
      .o_wb_ack(ack[0]), .o_wb_data(rdat[0]), .o_ready(rdy[0])
   );

   spell_rambus_responder #(
      .DEPTH(64), .WAIT_STATES(3), .INIT_ZERO(1'b1)
   ) u_d1 (
      .clock(clk), .reset(rst[1]), .i_wb_cyc(cyc[1]),
      .i_wb_stb(stb[1]), .i_wb_we(we[1]), .i_wb_sel(sel[1]),
      .i_wb_addr(addr[1]), .i_wb_data(wdat[1]),
      .o_wb_ack(ack[1]), .o_wb_data(rdat[1]), .o_ready(rdy[1])
   );

   spell_rambus_responder #(
      .DEPTH(16), .WAIT_STATES(2), .INIT_ZERO(1'b0)
   ) u_d2 (
      .clock(clk), .reset(rst[2]), .i_wb_cyc(cyc[2]),
      .i_wb_stb(stb[2]), .i_wb_we(we[2]), .i_wb_sel(sel[2]),
      .i_wb_addr(addr[2]), .i_wb_data(wdat[2]),
      .o_wb_ack(ack[2]), .o_wb_data(rdat[2]), .o_ready(rdy[2])
   );

   function automatic logic [31:0] expect_rd(input int k,
                                             input logic [9:0] a);
      int idx;
      idx = int'(a[9:2]);
      return (idx < dep[k]) ? mdl[k][idx] : 32'h0;
   endfunction

   task automatic model_wr(input int k, input logic [9:0] a,
                           input logic [3:0] s, input logic [31:0] d);
      int idx;
      idx = int'(a[9:2]);
      if (idx < dep[k])
         for (int b = 0; b < 4; b++)
            if (s[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic idle_bus(input int k);
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
   endtask

   // One full transfer from IDLE: latency, pulse width, data checks
   task automatic xfer(input int k, input bit w, input logic [9:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input string nm);
      int n;
      bit got;
      logic [31:0] exp_d;
      exp_d = w ? 32'h0 : expect_rd(k, a);
      @(negedge clk);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w;
      addr[k] = a; sel[k] = s; wdat[k] = d;
      n = 0; got = 1'b0;
      while (n < 40 && !got) begin
         @(posedge clk); #1;
         n++;
         if (ack[k]) got = 1'b1;
      end
      checks++;
      if (!got || n != ws[k] + 1) begin
         errs++;
         $display("FAIL %s latency: got=%0d cycles=%0d want=%0d",
                  nm, got, n, ws[k] + 1);
      end
      checks++;
      if (rdat[k] !== exp_d) begin
         errs++;
         $display("FAIL %s data: got=%h want=%h", nm, rdat[k], exp_d);
      end
      idle_bus(k);
      if (w) model_wr(k, a, s, d);
      @(posedge clk); #1;
      checks++;
      if (ack[k] !== 1'b0 || rdat[k] !== 32'h0) begin
         errs++;
         $display("FAIL %s pulse: ack=%b data=%h want ack=0 data=0",
                  nm, ack[k], rdat[k]);
      end
      @(posedge clk);
   endtask

   // Counts edges after reset release until o_ready; checks clear length
   task automatic wait_ready(input int k, input string nm);
      int n;
      n = 0;
      while (n < 400 && !rdy[k]) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != dep[k]) begin
         errs++;
         $display("FAIL %s ready: cycles=%0d want=%0d", nm, n, dep[k]);
      end
      for (int i = 0; i < 256; i++) mdl[k][i] = 32'h0;
   endtask

   task automatic test_reset;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; idle_bus(k);
         sel[k] = 4'h0; addr[k] = 10'h0; wdat[k] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ack[k] !== 1'b0 || rdat[k] !== 32'h0 ||
             rdy[k] !== (k == 2)) begin
            errs++;
            $display("FAIL reset_state[%0d]: ack=%b data=%h rdy=%b",
                     k, ack[k], rdat[k], rdy[k]);
         end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      fork
         wait_ready(0, "clear256");
         wait_ready(1, "clear64");
      join
      xfer(0, 1'b0, 10'h3FC, 4'hF, 32'h0, "read_3fc");
   endtask

   task automatic test_wait1;
      xfer(0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF, "wr_010");
      xfer(0, 1'b0, 10'h010, 4'hF, 32'h0, "rd_010");
   endtask

   task automatic test_byte_lanes;
      xfer(0, 1'b1, 10'h020, 4'hF, 32'h11223344, "bl_wr1");
      xfer(0, 1'b1, 10'h020, 4'h5, 32'hAABBCCDD, "bl_wr2");
      xfer(0, 1'b1, 10'h020, 4'h0, 32'h99999999, "bl_sel0");
      checks++;
      if (mdl[0][8] !== 32'h11BB33DD) begin
         errs++;
         $display("FAIL bl_model: got=%h want=11bb33dd", mdl[0][8]);
      end
      xfer(0, 1'b0, 10'h020, 4'h0, 32'h0, "bl_rd");
   endtask

   task automatic test_abort;
      bit seen;
      @(negedge clk);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
      addr[1] = 10'h030; sel[1] = 4'hF; wdat[1] = 32'h55;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      idle_bus(1);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ack[1]) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errs++;
         $display("FAIL abort_ack: ack seen=1 want 0");
      end
      xfer(1, 1'b0, 10'h030, 4'hF, 32'h0, "abort_rd");
   endtask

   task automatic test_out_of_range;
      xfer(1, 1'b1, 10'h000, 4'hF, 32'h01020304, "oor_w0");
      xfer(1, 1'b1, 10'h100, 4'hF, 32'hFFFFFFFF, "oor_wr");
      xfer(1, 1'b0, 10'h000, 4'hF, 32'h0, "oor_rd0");
      xfer(1, 1'b0, 10'h100, 4'hF, 32'h0, "oor_rd");
   endtask

   task automatic test_held_strobe;
      int n;
      int m;
      bit got;
      logic [31:0] exp_d;
      exp_d = expect_rd(0, 10'h010);
      @(negedge clk);
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
      addr[0] = 10'h010; sel[0] = 4'hF;
      n = 0; got = 1'b0;
      while (n < 40 && !got) begin
         @(posedge clk); #1;
         n++;
         if (ack[0]) got = 1'b1;
      end
      checks++;
      if (!got || n != ws[0] + 1) begin
         errs++;
         $display("FAIL held_first: got=%0d cycles=%0d", got, n);
      end
      m = 0; got = 1'b0;
      while (m < 20 && !got) begin
         @(posedge clk); #1;
         m++;
         if (m == 1) begin
            checks++;
            if (ack[0] !== 1'b0) begin
               errs++;
               $display("FAIL held_dup: ack=%b want 0", ack[0]);
            end
         end
         if (ack[0]) got = 1'b1;
      end
      checks++;
      if (!got || m != ws[0] + 3) begin
         errs++;
         $display("FAIL held_spacing: got=%0d cycles=%0d want=%0d",
                  got, m, ws[0] + 3);
      end
      checks++;
      if (rdat[0] !== exp_d) begin
         errs++;
         $display("FAIL held_data: got=%h want=%h", rdat[0], exp_d);
      end
      idle_bus(0);
      @(posedge clk);
      @(posedge clk);
   endtask

   task automatic test_random;
      int k;
      bit w;
      logic [9:0]  a;
      logic [3:0]  s;
      logic [31:0] d;
      for (int i = 0; i < 60; i++) begin
         k = i % 2;
         w = 1'($urandom_range(0, 1));
         a = (k == 1 && i % 3 != 0) ? 10'($urandom_range(0, 255))
                                     : 10'($urandom_range(0, 1023));
         s = 4'($urandom_range(0, 15));
         d = $urandom;
         xfer(k, w, a, s, d, "random");
      end
   endtask

   // Reset asserted mid-WAIT of a write: ack never fires, write lost
   task automatic reset_mid(input int k, input logic [9:0] a);
      bit seen;
      @(negedge clk);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1;
      addr[k] = a; sel[k] = 4'hF; wdat[k] = 32'hFFFFFFFF;
      @(posedge clk);
      @(negedge clk);
      rst[k] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ack[k] !== 1'b0 || rdy[k] !== (k == 2)) begin
         errs++;
         $display("FAIL rst_mid[%0d]: ack=%b rdy=%b", k, ack[k], rdy[k]);
      end
      @(negedge clk);
      rst[k] = 1'b0;
      idle_bus(k);
      if (k == 1) begin
         wait_ready(1, "reclear64");
      end else begin
         seen = 1'b0;
         repeat (6) begin
            @(posedge clk); #1;
            if (ack[k]) seen = 1'b1;
         end
         checks++;
         if (seen) begin
            errs++;
            $display("FAIL rst_mid_ack: ack seen=1 want 0");
         end
      end
   endtask

   task automatic test_reset_mid;
      xfer(2, 1'b1, 10'h00C, 4'hF, 32'h12345678, "rm_wr");
      reset_mid(2, 10'h00C);
      xfer(2, 1'b0, 10'h00C, 4'hF, 32'h0, "rm_rd");
      xfer(1, 1'b1, 10'h014, 4'hF, 32'hA5A5A5A5, "rm1_wr");
      reset_mid(1, 10'h014);
      xfer(1, 1'b0, 10'h014, 4'hF, 32'h0, "rm1_rd");
   endtask

   initial begin
      test_reset;
      test_wait1;
      test_byte_lanes;
      test_abort;
      test_out_of_range;
      test_held_strobe;
      test_random;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
